// File: rtl/booth_mul_sched.sv
// rtl/booth_mul_sched.sv - two-port round-robin radix-2 Booth sequential multiplier
//
// Shares one iterative Booth datapath between two requesters. A request is
// granted in IDLE, runs one Booth step per clock in RUN (N steps), and the
// result is held in DONE until the consumer takes it.
//
// Optional feature macro: BOOTH_SCHED_ZERO_BYPASS_EN
//   When defined, a request with a zero operand skips RUN and goes straight to
//   DONE with a zero product.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/ready/a/b      requester 0 operand handshake (signed N-bit a, b)
//   req1_valid/ready/a/b      requester 1 operand handshake (signed N-bit a, b)
//   rsp_valid/ready           result handshake
//   rsp_id                    requester that owns the result
//   rsp_product               signed 2N-bit product a*b
//   busy                      high whenever the block is not in IDLE
module booth_mul_sched #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*N-1:0] rsp_product,
  output logic           busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_gnt;
  logic [N:0]    acc;       // upper accumulator, one guard bit
  logic [N-1:0]  lo;        // holds A, shifted out as product low half fills in
  logic [N-1:0]  b_reg;
  logic          e;
  logic [CW-1:0] cnt;
  logic          id_reg;

  logic          gnt1;
  logic          accept;
  logic [N-1:0]  sel_a;
  logic [N-1:0]  sel_b;
  logic          zero_op;
  logic [N:0]    b_ext;
  logic [N:0]    sum;

  // On a tie, grant the requester that did not win last time.
  assign gnt1 = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;

  // Readys are gated by rst so they read low during the reset cycle itself.
  assign req0_ready = !rst && (state == IDLE) && req0_valid && !gnt1;
  assign req1_ready = !rst && (state == IDLE) && req1_valid && gnt1;
  assign accept     = req0_ready || req1_ready;

  assign sel_a = gnt1 ? req1_a : req0_a;
  assign sel_b = gnt1 ? req1_b : req0_b;

`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
  assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // B is sign-extended into N+1 bits so that -B stays exact for B = -2^(N-1).
  assign b_ext = {b_reg[N-1], b_reg};

  always_comb begin
    sum = acc;
    case ({lo[0], e})
      2'b10:   sum = acc - b_ext;
      2'b01:   sum = acc + b_ext;
      default: sum = acc;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_op ? DONE : RUN;
      RUN:  if (cnt == CW'(N - 1)) state_nxt = DONE;
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      acc      <= '0;
      lo       <= '0;
      b_reg    <= '0;
      e        <= 1'b0;
      cnt      <= '0;
      id_reg   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            b_reg    <= sel_b;
            // A zero lower half plus a cleared accumulator is the bypass result.
            lo       <= zero_op ? '0 : sel_a;
            acc      <= '0;
            e        <= 1'b0;
            cnt      <= '0;
            id_reg   <= gnt1;
            last_gnt <= gnt1;
          end
        end
        RUN: begin
          // Arithmetic shift of {sum, lo} right by one; the bit leaving lo is A[i].
          acc <= {sum[N], sum[N:1]};
          lo  <= {sum[0], lo[N-1:1]};
          e   <= lo[0];
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid   = (state == DONE);
  assign rsp_id      = id_reg;
  assign rsp_product = {acc[N-1:0], lo};
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_booth_mul_sched.sv
// tb/tb_booth_mul_sched.sv - scoreboard bench for booth_mul_sched
module tb_booth_mul_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [15:0] req0_a = '0;
  logic [15:0] req0_b = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [15:0] req1_a = '0;
  logic [15:0] req1_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [31:0] rsp_product;
  logic        busy;

  booth_mul_sched #(.N(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          id;
    logic [31:0] prod;
    int          vcyc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted response.
  bit          prev_valid = 1'b0;
  bit          cap_id;
  logic [31:0] cap_prod;
  int          accept_cyc = -1;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      chk("rsp_valid_in_reset", {63'd0, rsp_valid}, 64'd0);
    end else begin
      if (req0_ready && req1_ready) chk("both_ready", 64'd1, 64'd0);
      if (rsp_valid && !prev_valid) begin
        cap_id   = rsp_id;
        cap_prod = rsp_product;
        if (exp_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
        else chk("rsp_latency", 64'(cyc), 64'(exp_q[0].vcyc));
      end else if (rsp_valid && prev_valid) begin
        chk("hold_product", {32'd0, rsp_product}, {32'd0, cap_prod});
        chk("hold_id", {63'd0, rsp_id}, {63'd0, cap_id});
        chk("hold_busy", {63'd0, busy}, 64'd1);
      end
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        chk("rsp_id", {63'd0, rsp_id}, {63'd0, exp_q[0].id});
        chk("rsp_product", {32'd0, rsp_product}, {32'd0, exp_q[0].prod});
        void'(exp_q.pop_front());
        accept_cyc = cyc;
      end
      prev_valid = rsp_valid;
    end
  end

  // Issues one request and returns the cycle in which its handshake occurred.
  task automatic drive(input bit id, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] prod, input bit expect_rsp, output int hs);
    exp_t e;
    bit   got;
    int   lat;
    @(posedge clk);
    #1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    hs  = -1;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        got = 1'b1;
        hs  = cyc;
      end
    end
    if (!got) begin
      chk("handshake_timeout", 64'd1, 64'd0);
    end else begin
      lat = (BYPASS && (a == 16'd0 || b == 16'd0)) ? 1 : 17;
      if (expect_rsp) begin
        e.id = id; e.prod = prod; e.vcyc = hs + lat;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int h0, h1, hx, nbusy;
  bit stop;

  initial begin
    // Reset state, with req0 already requesting during reset.
    req0_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_req0_ready", {63'd0, req0_ready}, 64'd0);
    chk("reset_req1_ready", {63'd0, req1_ready}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_rsp_id", {63'd0, rsp_id}, 64'd0);
    chk("reset_rsp_product", {32'd0, rsp_product}, 64'd0);
    req0_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // 3 * -5, busy for exactly 17 cycles.
    drive(1'b0, 16'd3, 16'hFFFB, 32'hFFFFFFF1, 1'b1, h0);
    nbusy = 0;
    stop  = 1'b0;
    for (int k = 0; k < 100 && !stop; k++) begin
      @(negedge clk);
      if (busy) nbusy++; else stop = 1'b1;
    end
    chk("busy_cycles", 64'(nbusy), 64'd17);
    wait_idle();

    // Tie after reset: req0 first, then req1; the next tie goes to req0 again.
    do_reset();
    fork
      drive(1'b0, 16'd7, 16'd6, 32'd42, 1'b1, h0);
      drive(1'b1, 16'hFFFE, 16'd9, 32'hFFFFFFEE, 1'b1, h1);
    join
    chk("tie1_req0_first", {63'd0, h0 < h1}, 64'd1);
    fork
      drive(1'b0, 16'd2, 16'hFFFF, 32'hFFFFFFFE, 1'b1, h0);
      drive(1'b1, 16'hFFF9, 16'd3, 32'hFFFFFFEB, 1'b1, h1);
    join
    chk("tie2_req0_first", {63'd0, h0 < h1}, 64'd1);
    wait_idle();

    // Extreme operands.
    drive(1'b0, 16'h8000, 16'h8000, 32'h40000000, 1'b1, hx);
    drive(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, 1'b1, hx);
    drive(1'b0, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b1, hx);
    wait_idle();

    // Backpressure with req1 waiting through DONE.
    rsp_ready = 1'b0;
    drive(1'b0, 16'd100, 16'hFFFD, 32'hFFFFFED4, 1'b1, h0);
    fork
      drive(1'b1, 16'd5, 16'd5, 32'd25, 1'b1, h1);
      begin
        stop = 1'b0;
        for (int k = 0; k < 100 && !stop; k++) begin
          @(negedge clk);
          if (rsp_valid) stop = 1'b1;
        end
        if (!stop) chk("bp_rsp_timeout", 64'd1, 64'd0);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          chk("bp_req1_ready", {63'd0, req1_ready}, 64'd0);
          chk("bp_req1_valid", {63'd0, req1_valid}, 64'd1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    chk("bp_req1_after_accept", 64'(h1), 64'(accept_cyc + 1));
    wait_idle();

    // Reset during RUN step 8 discards the result and restores the pointer.
    drive(1'b0, 16'd11, 16'd13, 32'd143, 1'b0, h0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    fork
      drive(1'b0, 16'd11, 16'd13, 32'd143, 1'b1, h0);
      drive(1'b1, 16'hFFFC, 16'hFFFC, 32'd16, 1'b1, h1);
    join
    chk("abort_ptr_req0_first", {63'd0, h0 < h1}, 64'd1);
    wait_idle();

    // Zero operand: latency depends on the bypass build option.
    drive(1'b0, 16'd0, 16'd1234, 32'd0, 1'b1, hx);
    wait_idle();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
